// File: rtl/bcd_x3_sched.sv
// Round-robin scheduler that serializes one BCD digit at a time to an external
// bit-serial excess-3 converter and returns the collected result to the requester.
module bcd_x3_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_digit,
  output logic [NREQ-1:0]   gnt,
  output logic              ser_inval,
  output logic              ser_in,
  input  logic              ser_outval,
  input  logic              ser_out,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_code,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, RESP} state_t;

  state_t         state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] id_reg;
  logic [3:0]     digit_reg;
  logic [3:0]     acc_reg;
  logic [1:0]     bit_reg;

  logic           pick_ok;
  logic [IDW-1:0] pick_id;
  logic [3:0]     pick_digit;
  logic           can_grant;
  int             idx;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick_ok = 1'b0;
    pick_id = '0;
    idx     = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_reg) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_ok && req[idx]) begin
        pick_ok = 1'b1;
        pick_id = IDW'(idx);
      end
    end
  end

  assign pick_digit = req_digit[4*int'(pick_id) +: 4];
  assign can_grant  = !rst && pick_ok && (state_reg == IDLE || state_reg == RESP);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign gnt[gi] = can_grant && (pick_id == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      digit_reg <= '0;
      acc_reg   <= '0;
      bit_reg   <= '0;
      ser_inval <= 1'b0;
      ser_in    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_code  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE, RESP: begin
          if (can_grant) begin
            ptr_reg   <= (pick_id == IDW'(NREQ-1)) ? '0 : pick_id + 1'b1;
            id_reg    <= pick_id;
            digit_reg <= pick_digit;
            acc_reg   <= '0;
            busy      <= 1'b1;
            if (pick_digit > 4'd9) begin
              // Invalid digit never reaches the converter; answer immediately.
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_code  <= '0;
              rsp_id    <= pick_id;
            end else begin
              state_reg <= SEND;
              ser_inval <= 1'b1;
              ser_in    <= pick_digit[0];
              bit_reg   <= '0;
            end
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        SEND: begin
          // Converter beats lag the input by one cycle, so beat k lands in bit-cycle k+1.
          if (ser_outval && bit_reg != 2'd0) acc_reg[bit_reg - 2'd1] <= ser_out;
          if (bit_reg == 2'd3) begin
            state_reg <= DRAIN;
            ser_inval <= 1'b0;
            ser_in    <= 1'b0;
          end else begin
            bit_reg <= bit_reg + 2'd1;
            ser_in  <= digit_reg[bit_reg + 2'd1];
          end
        end
        DRAIN: begin
          state_reg <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_id    <= id_reg;
          rsp_code  <= {(ser_outval ? ser_out : acc_reg[3]), acc_reg[2:0]};
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_x3_sched.sv
// Directed bench for bcd_x3_sched with a behavioural serial excess-3 converter.
module tb_bcd_x3_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [4*NREQ-1:0] req_digit = '0;
  logic [NREQ-1:0]   gnt;
  logic              ser_inval, ser_in;
  logic              ser_outval = 1'b0;
  logic              ser_out = 1'b0;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_code;
  logic              rsp_err;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_x3_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_digit(req_digit), .gnt(gnt),
    .ser_inval(ser_inval), .ser_in(ser_in), .ser_outval(ser_outval), .ser_out(ser_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_code(rsp_code), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Converter model: adds 3 to the bits seen so far, emits bit k one cycle after input bit k.
  logic       pend_v = 1'b0, pend_b = 1'b0, inject = 1'b0, inject_b = 1'b0;
  logic [1:0] cv_k = '0;
  logic [3:0] cv_bits = '0, part = '0;
  always @(negedge clk) begin
    #3;
    if (rst) begin
      cv_k = '0; cv_bits = '0; pend_v = 1'b0;
    end else if (ser_inval) begin
      if (cv_k == 2'd0) cv_bits = '0;
      cv_bits[cv_k] = ser_in;
      part   = cv_bits + 4'd3;
      pend_b = part[cv_k];
      pend_v = 1'b1;
      cv_k   = cv_k + 2'd1;
    end else begin
      pend_v = 1'b0;
    end
  end
  always @(posedge clk) begin
    #1;
    ser_outval = pend_v | inject;
    ser_out    = inject ? inject_b : pend_b;
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req = '0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; req = 4'b0001; req_digit = 16'h0005;
    @(negedge clk); #1;
    n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_checks++; if ({ser_inval, ser_in, rsp_valid, rsp_err, busy} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=00000", {ser_inval, ser_in, rsp_valid, rsp_err, busy}); end
    n_checks++; if (rsp_code !== 4'd0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp code=%0d id=%0d exp=0/0", rsp_code, rsp_id); end
    req = '0;
    @(negedge clk); rst = 1'b0;
    $display("reset: checked outputs under reset");
  endtask

  task automatic test_single();
    logic [3:0] d;
    d = 4'd5;
    @(negedge clk); req = 4'b0001; req_digit = 16'h0005; #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); req = '0; #1;
      if (k <= 4) begin
        n_checks++; if (ser_inval !== 1'b1 || ser_in !== d[k-1]) begin n_fail++; $display("FAIL single_bit%0d inval=%b in=%b exp=1/%b", k-1, ser_inval, ser_in, d[k-1]); end
      end else if (k == 5) begin
        n_checks++; if (ser_inval !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain inval=%b valid=%b exp=0/0", ser_inval, rsp_valid); end
      end else begin
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_code !== 4'd8 || rsp_err !== 1'b0)
          begin n_fail++; $display("FAIL single_rsp valid=%b id=%0d code=%0d err=%b exp=1/0/8/0", rsp_valid, rsp_id, rsp_code, rsp_err); end
      end
    end
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_code !== 4'd8) begin n_fail++; $display("FAIL single_idle busy=%b valid=%b code=%0d exp=0/0/8", busy, rsp_valid, rsp_code); end
    $display("single: digit 5 -> code %0d", rsp_code);
  endtask

  task automatic test_round_robin();
    logic [3:0] codes [4];
    logic [3:0] clr;
    int g_exp, r_exp, last;
    codes[0] = 4'd3; codes[1] = 4'd12; codes[2] = 4'd6; codes[3] = 4'd10;
    g_exp = 0; r_exp = 0; last = 0; clr = '0;
    do_reset();
    for (int cyc = 0; cyc < 32; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin req = 4'hF; req_digit = {4'd7, 4'd3, 4'd9, 4'd0}; end
      req = req & ~clr; clr = '0; #1;
      if (gnt !== 4'b0) begin
        n_checks++; if (g_exp > 3 || gnt !== (4'b0001 << g_exp)) begin n_fail++; $display("FAIL rr_gnt got=%b exp_id=%0d", gnt, g_exp); end
        if (g_exp > 0) begin
          n_checks++; if (cyc - last != 6) begin n_fail++; $display("FAIL rr_spacing got=%0d exp=6", cyc - last); end
        end
        last = cyc; clr = gnt; g_exp++;
      end
      if (rsp_valid === 1'b1) begin
        n_checks++; if (r_exp > 3 || rsp_id !== IDW'(r_exp) || rsp_code !== codes[r_exp & 3] || rsp_err !== 1'b0)
          begin n_fail++; $display("FAIL rr_rsp id=%0d code=%0d err=%b exp_id=%0d exp_code=%0d", rsp_id, rsp_code, rsp_err, r_exp, codes[r_exp & 3]); end
        $display("rr: response id=%0d code=%0d", rsp_id, rsp_code);
        r_exp++;
      end
    end
    n_checks++; if (g_exp != 4 || r_exp != 4) begin n_fail++; $display("FAIL rr_count grants=%0d rsps=%0d exp=4/4", g_exp, r_exp); end
  endtask

  task automatic test_error();
    do_reset();
    @(negedge clk); req = 4'b1100; req_digit = {4'd4, 4'd11, 4'd0, 4'd0}; #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL err_gnt got=%b exp=0100", gnt); end
    @(negedge clk); req = 4'b1000; #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_code !== 4'd0 || rsp_id !== 2'd2 || ser_inval !== 1'b0)
      begin n_fail++; $display("FAIL err_rsp valid=%b err=%b code=%0d id=%0d inval=%b exp=1/1/0/2/0", rsp_valid, rsp_err, rsp_code, rsp_id, ser_inval); end
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL err_gnt_resp got=%b exp=1000", gnt); end
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk); req = '0; #1;
      if (k == 2) begin
        n_checks++; if (ser_inval !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_hold inval=%b valid=%b err=%b exp=1/0/1", ser_inval, rsp_valid, rsp_err); end
      end
      if (k == 7) begin
        n_checks++; if (rsp_valid !== 1'b1 || rsp_code !== 4'd7 || rsp_id !== 2'd3 || rsp_err !== 1'b0)
          begin n_fail++; $display("FAIL err_next valid=%b code=%0d id=%0d err=%b exp=1/7/3/0", rsp_valid, rsp_code, rsp_id, rsp_err); end
      end
    end
    $display("error: digit 11 flagged, digit 4 -> code %0d", rsp_code);
  endtask

  task automatic test_back_to_back();
    int grants, rsps, last, busy_drops;
    grants = 0; rsps = 0; last = 0; busy_drops = 0;
    for (int cyc = 0; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin req = 4'b0010; req_digit = {4'd0, 4'd0, 4'd2, 4'd0}; end
      if (cyc == 24) req = '0;
      #1;
      if (cyc > 0 && busy !== 1'b1) busy_drops++;
      if (gnt !== 4'b0) begin
        n_checks++; if (gnt !== 4'b0010 || (grants > 0 && cyc - last != 6)) begin n_fail++; $display("FAIL b2b_gnt got=%b gap=%0d exp=0010/6", gnt, cyc - last); end
        last = cyc; grants++;
      end
      if (rsp_valid === 1'b1) begin
        n_checks++; if (rsp_code !== 4'd5 || rsp_id !== 2'd1) begin n_fail++; $display("FAIL b2b_rsp code=%0d id=%0d exp=5/1", rsp_code, rsp_id); end
        $display("b2b: response id=%0d code=%0d at cycle %0d", rsp_id, rsp_code, cyc);
        rsps++;
      end
    end
    n_checks++; if (grants != 4 || rsps != 4) begin n_fail++; $display("FAIL b2b_count grants=%0d rsps=%0d exp=4/4", grants, rsps); end
    n_checks++; if (busy_drops != 0) begin n_fail++; $display("FAIL b2b_busy drops=%0d exp=0", busy_drops); end
    @(negedge clk);
  endtask

  task automatic test_idle_beat();
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_state busy=%b exp=0", busy); end
    inject = 1'b1; inject_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0 || rsp_code !== 4'd5) begin n_fail++; $display("FAIL idle_beat valid=%b code=%0d exp=0/5", rsp_valid, rsp_code); end
    end
    inject = 1'b0;
    $display("idle: stray beats ignored, code=%0d", rsp_code);
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    do_reset();
    @(negedge clk); req = 4'b0001; req_digit = 16'h0009; #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_gnt got=%b exp=0001", gnt); end
    @(negedge clk); req = '0;
    @(negedge clk); rst = 1'b1; #1;
    n_checks++; if (ser_inval !== 1'b1) begin n_fail++; $display("FAIL mid_send inval=%b exp=1", ser_inval); end
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if ({gnt, ser_inval, ser_in, rsp_valid, rsp_err, busy} !== 9'b0 || rsp_code !== 4'd0 || rsp_id !== 2'd0)
      begin n_fail++; $display("FAIL mid_reset flags=%b code=%0d id=%0d exp=0/0/0", {gnt, ser_inval, ser_in, rsp_valid, rsp_err, busy}, rsp_code, rsp_id); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 1'b0) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL mid_no_rsp strays=%0d exp=0", stray); end
    @(negedge clk); req = 4'b0010; req_digit = {4'd0, 4'd0, 4'd6, 4'd0}; #1;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_regnt got=%b exp=0010", gnt); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); req = '0; #1;
      if (k == 6) begin
        n_checks++; if (rsp_valid !== 1'b1 || rsp_code !== 4'd9 || rsp_id !== 2'd1 || rsp_err !== 1'b0)
          begin n_fail++; $display("FAIL mid_rsp valid=%b code=%0d id=%0d err=%b exp=1/9/1/0", rsp_valid, rsp_code, rsp_id, rsp_err); end
      end
    end
    $display("reset_mid: word discarded, digit 6 -> code %0d", rsp_code);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_error();
    test_back_to_back();
    test_idle_beat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
